// File: rtl/int_ctrl.sv
// ============================================================================
// Module   : int_ctrl
// Purpose  : Memory-mapped interrupt controller (pending/enable/claim/complete)
//            for the cpu data bus. Define INT_CTRL_EDGE_EN for rising-edge
//            source detection; level-sensitive sources otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl #(
    parameter int          NUM_SRC   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0410
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [31:0]        access_addr,
    input  logic               w_en,
    input  logic [31:0]        w_data,
    input  logic               r_en,
    output logic               sel,
    output logic [31:0]        r_data,
    output logic               int_req,
    output logic [4:0]         active_id
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_wait    = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;

    localparam logic [1:0] c_reg_pending  = 2'd0;
    localparam logic [1:0] c_reg_enable   = 2'd1;
    localparam logic [1:0] c_reg_claim    = 2'd2;
    localparam logic [1:0] c_reg_complete = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_int_req;
    logic [4:0]         r_active_id;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_claim_clr;
    logic [4:0]         w_winner;
    logic [4:0]         w_claim_id;
    logic               w_has_cand;
    logic [31:0]        w_offset;
    logic [1:0]         w_reg;
    logic               w_wr_pending;
    logic               w_wr_enable;
    logic               w_wr_complete;
    logic               w_rd_claim;
    logic               w_claim_fire;
    logic               w_complete_ok;
    logic [31:0]        w_rdata;
    logic               w_unused_bits;

    // Unsigned wrap makes a single compare cover the whole 16-byte window.
    assign w_offset = access_addr - BASE_ADDR;
    assign sel      = (w_offset < 32'd16);
    assign w_reg    = w_offset[3:2];

    assign w_wr_pending  = w_en && sel && (w_reg == c_reg_pending);
    assign w_wr_enable   = w_en && sel && (w_reg == c_reg_enable);
    assign w_wr_complete = w_en && sel && (w_reg == c_reg_complete);
    assign w_rd_claim    = r_en && sel && (w_reg == c_reg_claim);

`ifdef INT_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] r_src_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_src_q <= '0;
        end else begin
            r_src_q <= src;
        end
    end

    assign w_set = src & ~r_src_q;
`else
    assign w_set = src;
`endif

    assign w_cand     = r_pending & r_enable;
    assign w_has_cand = |w_cand;

    // Scan downwards so the lowest set index is the last assignment.
    always_comb begin
        w_winner = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_winner = i[4:0];
            end
        end
    end

    assign w_claim_id    = w_winner + 5'd1;
    assign w_claim_fire  = w_rd_claim && (r_state == c_st_wait) && w_has_cand;
    assign w_complete_ok = w_wr_complete && (r_state == c_st_service)
                           && (w_data[4:0] == r_active_id);
    assign w_w1c         = w_wr_pending ? w_data[NUM_SRC-1:0] : '0;
    assign w_claim_clr   = w_claim_fire ? (NUM_SRC'(1) << w_winner) : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_has_cand) begin
                    w_state_next = c_st_wait;
                end
            end
            c_st_wait: begin
                if (!w_has_cand) begin
                    w_state_next = c_st_idle;
                end else if (w_claim_fire) begin
                    w_state_next = c_st_service;
                end
            end
            c_st_service: begin
                if (w_complete_ok) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_int_req   <= 1'b0;
            r_active_id <= 5'd0;
            r_pending   <= '0;
            r_enable    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_int_req <= (w_state_next == c_st_wait);
            // Set is OR'd in last so a new request beats W1C and claim clears.
            r_pending <= (r_pending & ~w_w1c & ~w_claim_clr) | w_set;
            if (w_wr_enable) begin
                r_enable <= w_data[NUM_SRC-1:0];
            end
            if (w_claim_fire) begin
                r_active_id <= w_claim_id;
            end else if (w_complete_ok) begin
                r_active_id <= 5'd0;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (sel) begin
            case (w_reg)
                c_reg_pending: w_rdata = 32'(r_pending);
                c_reg_enable:  w_rdata = 32'(r_enable);
                c_reg_claim:   w_rdata = ((r_state == c_st_wait) && w_has_cand)
                                         ? 32'(w_claim_id) : 32'd0;
                default:       w_rdata = 32'd0;
            endcase
        end
    end

    assign r_data    = w_rdata;
    assign int_req   = r_int_req;
    assign active_id = r_active_id;

    assign w_unused_bits = ^{w_data, w_offset};

endmodule

`default_nettype wire

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Memory-mapped interrupt controller that replaces the raw OR of peripheral int_req lines (BUTTON, UART) feeding the cpu.
- Latches requests into a pending register, masks them with an enable register, and selects the lowest-index source as highest priority.
- Drives the single cpu int_req and sequences claim/complete so that only one interrupt is in service at a time.
- Sits beside data_mem on the cpu data bus; its read data joins the top-level dmem_r_data mux.

Parameters:
- NUM_SRC, 2, number of interrupt sources (1..31); src[0] has the highest priority.
- BASE_ADDR, 32'h0000_0410, word-aligned base of the 4-register window.

Ports:
- clock  input  1  core clock (same clock as cpu/data_mem)
- reset  input  1  synchronous, active-high reset
- src  input  NUM_SRC  peripheral interrupt request lines, synchronous to clock
- access_addr  input  32  cpu data address (dmem_rw_addr)
- w_en  input  1  cpu store strobe
- w_data  input  32  cpu store data (rs2_data)
- r_en  input  1  cpu load strobe, one cycle per load
- sel  output  1  combinational; 1 when access_addr is in [BASE_ADDR, BASE_ADDR+15]
- r_data  output  32  combinational read data; 0 when sel=0
- int_req  output  1  registered interrupt request to cpu
- active_id  output  5  registered id of the source in service (id = index+1; 0 = none)

Behaviour:
- Clock/reset: one clock (clock); reset is synchronous and active-high. On reset: pending=0, enable=0, state=IDLE, int_req=0, active_id=0, edge-history register=0.
- Register map (offset, access):
  - +0x0 PENDING: R, W1C on bits [NUM_SRC-1:0].
  - +0x4 ENABLE: RW.
  - +0x8 CLAIM: read only, with side effect.
  - +0xC COMPLETE: write only.
  - Unimplemented bits read as 0. Reads of COMPLETE and writes to CLAIM have no effect.
- Pending set condition: per bit, set when src[i] is asserted (see Optional Feature). If the set condition and a W1C clear hit the same bit in the same cycle, set wins.
- Candidate: pending & enable. The winner is the lowest set index. CLAIM read value = winner index+1, or 0 if there is no candidate or state != WAIT.
- FSM:
  - IDLE: if candidate != 0, go to WAIT next cycle.
  - WAIT: int_req=1.
    - If candidate becomes 0 (W1C or ENABLE write), return to IDLE.
    - On a CLAIM read with candidate != 0: clear the winner's pending bit (set-wins still applies); latch active_id = winner+1; go to IN_SERVICE.
  - IN_SERVICE: int_req=0.
    - CLAIM reads return 0 and have no side effect.
    - A COMPLETE write with w_data[4:0] == active_id sets active_id=0 and returns to IDLE.
    - A mismatched COMPLETE write is ignored.
- int_req is registered and equals (next state == WAIT). Latency: src asserted in cycle N → pending set at edge N+1 → int_req high at edge N+2.
- No nesting. New requests accumulate in PENDING during IN_SERVICE and are re-evaluated in IDLE after complete.
- A COMPLETE write in IDLE or WAIT is ignored.
- Reset during IN_SERVICE or WAIT returns to the reset state above on the next edge; no partial claim survives.
- Writes to bits ≥ NUM_SRC are dropped.

Optional Feature:
- Macro: INT_CTRL_EDGE_EN.
- Defined: each source is registered every cycle. A pending bit sets only on a rising edge (src[i]=1 while the previous sample was 0). A held-high source sets pending once.
- Undefined: level mode. A pending bit sets every cycle src[i]=1, so W1C or claim of a still-asserted source re-pends it on the next cycle. The edge-history register is not built.

Test Plan:
- Reset, then single source: ENABLE=0x3; pulse src[1] for 1 cycle (edge mode) → PENDING=0x2 at N+1, int_req=1 at N+2; CLAIM read returns 2, int_req=0, active_id=2; COMPLETE write 2 → IDLE, active_id=0.
- Priority: src=2'b11 for one cycle, ENABLE=0x3 → first CLAIM returns 1 and PENDING=0x2; COMPLETE 1; int_req re-asserts; second CLAIM returns 2.
- Masking: ENABLE=0x1; pulse src[1] → PENDING=0x2, int_req stays 0. Write ENABLE=0x3 → int_req=1 two cycles later.
- Boundary cases:
  - W1C write 0x1 to PENDING in the same cycle src[0] rises → PENDING[0] stays 1.
  - COMPLETE with the wrong id (3) during IN_SERVICE → state unchanged.
  - CLAIM read during IN_SERVICE → returns 0.
- Reset mid-service: claim source 1, then assert reset for 1 cycle → int_req=0, active_id=0, PENDING=0, ENABLE=0.
- Level mode (macro undefined): hold src[0]=1; claim returns 1; after COMPLETE, PENDING[0]=1 again and int_req re-asserts.
